// File: rtl/param_loader_pkg.sv
// Shared types and defaults for the parameter loader: FSM encoding, default
// geometry, default reset/sentinel words and the symbolic word indices.
package param_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_CHECK,
    S_COMMIT,
    S_FAIL
  } state_t;

  localparam int NUM_PARAMS_DEF = 11;
  localparam int DATA_W_DEF     = 32;
  localparam int ADDR_W_DEF     = 4;
  localparam int RD_LAT_DEF     = 2;

  localparam int IDX_HEIGHT       = 0;
  localparam int IDX_WIDTH        = 1;
  localparam int IDX_FRAME_WORDS  = 2;
  localparam int IDX_BPP          = 3;
  localparam int IDX_GAIN         = 4;
  localparam int IDX_OFFSET       = 5;
  localparam int IDX_ROWS_SKIP    = 6;
  localparam int IDX_WIN_H        = 7;
  localparam int IDX_WIN_W        = 8;
  localparam int IDX_MODE         = 9;
  localparam int IDX_CORR_ROUTINE = 10;

  // Word 10 first, word 0 last; MODE uses all-ones since 0 is a legal mode.
  localparam logic [NUM_PARAMS_DEF*DATA_W_DEF-1:0] RESET_VALS_DEF = {
    32'h0000_0000,
    32'hFFFF_FFFF,
    {9{32'h0000_0000}}
  };

endpackage

// File: rtl/param_loader_check.sv
// Combinational sentinel check: pass unless some required word still holds
// its reset value.
module param_check
  import param_pkg::*;
#(
  parameter int                               NUM_PARAMS = NUM_PARAMS_DEF,
  parameter int                               DATA_W     = DATA_W_DEF,
  parameter logic [NUM_PARAMS-1:0]            REQ_MASK   = '1,
  parameter logic [NUM_PARAMS*DATA_W-1:0]     RESET_VALS = RESET_VALS_DEF
) (
  input  logic [NUM_PARAMS*DATA_W-1:0] shadow,
  output logic                         pass
);

  always_comb begin
    // NOTE: giving pass a value before the loop keeps this block free of latches.
    pass = 1'b1;
    for (int i = 0; i < NUM_PARAMS; i++) begin
      if (REQ_MASK[i] && (shadow[i*DATA_W +: DATA_W] == RESET_VALS[i*DATA_W +: DATA_W])) begin
        pass = 1'b0;
      end
    end
  end

endmodule

// File: rtl/param_loader.sv
// Fetches NUM_PARAMS words from a parameter BRAM into a shadow set, checks
// them against their sentinels and commits the whole set atomically.
module param_loader
  import param_pkg::*;
#(
  parameter int                           NUM_PARAMS = NUM_PARAMS_DEF,
  parameter int                           DATA_W     = DATA_W_DEF,
  parameter int                           ADDR_W     = ADDR_W_DEF,
  parameter int                           RD_LAT     = RD_LAT_DEF,
  parameter logic [NUM_PARAMS-1:0]        REQ_MASK   = '1,
  parameter logic [NUM_PARAMS*DATA_W-1:0] RESET_VALS = RESET_VALS_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [DATA_W-1:0]            data_in,
  output logic [ADDR_W-1:0]            addr,
  output logic                         ea,
  output logic                         we,
  output logic [NUM_PARAMS*DATA_W-1:0] params,
  output logic                         busy,
  output logic                         param_done,
  output logic                         param_err
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_PARAMS - 1);
  localparam logic [2:0]        WAIT_LOAD = 3'(RD_LAT - 1);

  state_t                              state;
  logic [ADDR_W-1:0]                   idx;
  logic [2:0]                          wait_cnt;
  logic [NUM_PARAMS-1:0][DATA_W-1:0]   shadow;
  logic                                pass;

  assign ea = 1'b1;
  assign we = 1'b0;

  param_check #(
    .NUM_PARAMS (NUM_PARAMS),
    .DATA_W     (DATA_W),
    .REQ_MASK   (REQ_MASK),
    .RESET_VALS (RESET_VALS)
  ) u_check (
    .shadow (shadow),
    .pass   (pass)
  );

  // A word spends ISSUE + (RD_LAT-1) WAIT cycles + CAPTURE = RD_LAT+1 cycles;
  // the address is already driven on entry to ISSUE, so data is valid at CAPTURE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      addr       <= '0;
      wait_cnt   <= '0;
      // NOTE: shadow is a small flop array, not a RAM macro, so it can take the async reset.
      shadow     <= RESET_VALS;
      params     <= RESET_VALS;
      busy       <= 1'b0;
      param_done <= 1'b0;
      param_err  <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_ISSUE;
            idx        <= '0;
            addr       <= '0;
            busy       <= 1'b1;
            param_done <= 1'b0;
            param_err  <= 1'b0;
          end
        end
        S_ISSUE: begin
          addr <= idx;
          if (RD_LAT == 1) begin
            state <= S_CAPTURE;
          end else begin
            wait_cnt <= WAIT_LOAD;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt == 3'd1) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          shadow[idx] <= data_in;
          if (idx == LAST_IDX) begin
            state <= S_CHECK;
          end else begin
            idx   <= idx + ADDR_W'(1);
            addr  <= idx + ADDR_W'(1);
            state <= S_ISSUE;
          end
        end
        S_CHECK: begin
          state <= pass ? S_COMMIT : S_FAIL;
        end
        S_COMMIT: begin
          params     <= shadow;
          param_done <= 1'b1;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        S_FAIL: begin
          param_err <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_loader.sv
// Randomized self-checking bench for param_loader: two instances (RD_LAT=2 with
// full mask, RD_LAT=4 with the GAIN word unmasked) against a spec-level model.
module tb_param_loader;
  import param_pkg::*;

  localparam int NP    = NUM_PARAMS_DEF;
  localparam int DW    = DATA_W_DEF;
  localparam int AW    = ADDR_W_DEF;
  localparam int PW    = NP * DW;
  localparam int LAT_A = 2;
  localparam int LAT_B = 4;
  localparam logic [NP-1:0] MASK_A = '1;
  localparam logic [NP-1:0] MASK_B = ~(NP'(1) << IDX_GAIN);
  localparam logic [PW-1:0] RV     = RESET_VALS_DEF;

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, start_b;
  logic [DW-1:0] data_a, data_b;
  logic [AW-1:0] addr_a, addr_b;
  logic ea_a, ea_b, we_a, we_b;
  logic [PW-1:0] params_a, params_b;
  logic busy_a, busy_b, done_a, done_b, err_a, err_b;

  logic [DW-1:0] mem_a [NP];
  logic [DW-1:0] mem_b [NP];
  logic [DW-1:0] pipe_a [LAT_A];
  logic [DW-1:0] pipe_b [LAT_B];
  logic [DW-1:0] nom [NP];

  logic [PW-1:0] exp_a, exp_b;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  param_loader #(.RD_LAT(LAT_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .data_in(data_a), .addr(addr_a),
    .ea(ea_a), .we(we_a), .params(params_a), .busy(busy_a),
    .param_done(done_a), .param_err(err_a)
  );

  param_loader #(.RD_LAT(LAT_B), .REQ_MASK(MASK_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .data_in(data_b), .addr(addr_b),
    .ea(ea_b), .we(we_b), .params(params_b), .busy(busy_b),
    .param_done(done_b), .param_err(err_b)
  );

  // BRAM models: data_in reflects mem[addr] RD_LAT edges after addr changes.
  always @(posedge clk) begin
    pipe_a[0] <= mem_a[addr_a];
    for (int k = 1; k < LAT_A; k++) pipe_a[k] <= pipe_a[k-1];
    pipe_b[0] <= mem_b[addr_b];
    for (int k = 1; k < LAT_B; k++) pipe_b[k] <= pipe_b[k-1];
  end
  assign data_a = pipe_a[LAT_A-1];
  assign data_b = pipe_b[LAT_B-1];

  // One full load on instance a (sel=0) or b (sel=1), checked every cycle.
  task automatic run_load(input bit sel, input bit pulse_mid, input string name);
    int lat, total, exp_addr;
    logic [NP-1:0] mask;
    logic [PW-1:0] prev, nxt, o_params;
    logic [DW-1:0] words [NP];
    bit pass;
    logic o_busy, o_done, o_err, o_ea, o_we;
    logic [AW-1:0] o_addr;

    lat   = sel ? LAT_B : LAT_A;
    total = NP * (lat + 1) + 2;
    mask  = sel ? MASK_B : MASK_A;
    prev  = sel ? exp_b : exp_a;
    if (sel) words = mem_b; else words = mem_a;
    pass = 1'b1;
    for (int i = 0; i < NP; i++)
      if (mask[i] && words[i] == RV[i*DW +: DW]) pass = 1'b0;
    nxt = prev;
    if (pass) for (int i = 0; i < NP; i++) nxt[i*DW +: DW] = words[i];

    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= total + 1; k++) begin
      @(negedge clk);
      o_busy   = sel ? busy_b   : busy_a;
      o_done   = sel ? done_b   : done_a;
      o_err    = sel ? err_b    : err_a;
      o_ea     = sel ? ea_b     : ea_a;
      o_we     = sel ? we_b     : we_a;
      o_addr   = sel ? addr_b   : addr_a;
      o_params = sel ? params_b : params_a;
      exp_addr = (k < NP * (lat + 1)) ? k / (lat + 1) : NP - 1;

      n_cmp++;
      if ({o_ea, o_we} !== 2'b10) begin
        n_bad++;
        $display("FAIL %s k=%0d ea/we got=%b%b want=10", name, k, o_ea, o_we);
      end
      n_cmp++;
      if (o_addr !== AW'(exp_addr)) begin
        n_bad++;
        $display("FAIL %s k=%0d addr got=%0d want=%0d", name, k, o_addr, exp_addr);
      end
      if (k < total) begin
        n_cmp++;
        if ({o_busy, o_done, o_err} !== 3'b100) begin
          n_bad++;
          $display("FAIL %s k=%0d busy/done/err got=%b%b%b want=100", name, k, o_busy, o_done, o_err);
        end
        n_cmp++;
        if (o_params !== prev) begin
          n_bad++;
          $display("FAIL %s k=%0d params changed mid-load got=%h want=%h", name, k, o_params, prev);
        end
      end else begin
        n_cmp++;
        if ({o_busy, o_done, o_err} !== {1'b0, pass, !pass}) begin
          n_bad++;
          $display("FAIL %s k=%0d busy/done/err got=%b%b%b want=0%b%b", name, k,
                   o_busy, o_done, o_err, pass, !pass);
        end
        n_cmp++;
        if (o_params !== nxt) begin
          n_bad++;
          $display("FAIL %s k=%0d params got=%h want=%h", name, k, o_params, nxt);
        end
      end
      // Optional stray starts: during the load and in the COMMIT/FAIL cycle.
      if (sel) start_b = pulse_mid && (k == 5 || k == 20 || k == total - 1);
      else     start_a = pulse_mid && (k == 5 || k == 20 || k == total - 1);
    end
    start_a = 1'b0;
    start_b = 1'b0;
    if (sel) exp_b = nxt; else exp_a = nxt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    exp_a = RV;
    exp_b = RV;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy_a, done_a, err_a, ea_a, we_a, addr_a} !== {5'b00010, AW'(0)}) begin
      n_bad++;
      $display("FAIL reset_a status got=%b%b%b%b%b addr=%0d", busy_a, done_a, err_a, ea_a, we_a, addr_a);
    end
    n_cmp++;
    if ({busy_b, done_b, err_b, ea_b, we_b, addr_b} !== {5'b00010, AW'(0)}) begin
      n_bad++;
      $display("FAIL reset_b status got=%b%b%b%b%b addr=%0d", busy_b, done_b, err_b, ea_b, we_b, addr_b);
    end
    n_cmp++;
    if (params_a !== RV || params_b !== RV) begin
      n_bad++;
      $display("FAIL reset params got a=%h b=%h want=%h", params_a, params_b, RV);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy_a, done_a, err_a, busy_b, done_b, err_b} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_release status got=%b%b%b %b%b%b want=000 000",
               busy_a, done_a, err_a, busy_b, done_b, err_b);
    end
  endtask

  task automatic test_sentinel_fail();
    mem_a = nom;
    mem_a[IDX_GAIN] = RV[IDX_GAIN*DW +: DW];
    run_load(1'b0, 1'b0, "sentinel_fail");
  endtask

  task automatic test_nominal();
    mem_a = nom;
    run_load(1'b0, 1'b0, "nominal");
  endtask

  task automatic test_mask_latency();
    mem_b = nom;
    mem_b[IDX_GAIN] = RV[IDX_GAIN*DW +: DW];
    run_load(1'b1, 1'b0, "mask_latency");
  endtask

  task automatic test_busy_reload();
    mem_a = nom;
    run_load(1'b0, 1'b1, "busy_ignore");
    mem_a[IDX_HEIGHT] = 32'd500;
    run_load(1'b0, 1'b0, "reload");
  endtask

  task automatic test_reset_mid_load();
    mem_a = nom;
    mem_a[IDX_WIDTH] = 32'd640;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    n_cmp++;
    if (busy_a !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_load busy before reset got=%b want=1", busy_a);
    end
    #1 rst_n = 1'b0;
    #1;
    exp_a = RV;
    exp_b = RV;
    n_cmp++;
    if ({busy_a, done_a, err_a, ea_a, we_a, addr_a} !== {5'b00010, AW'(0)}) begin
      n_bad++;
      $display("FAIL mid_load async status got=%b%b%b%b%b addr=%0d", busy_a, done_a, err_a, ea_a, we_a, addr_a);
    end
    n_cmp++;
    if (params_a !== RV) begin
      n_bad++;
      $display("FAIL mid_load async params got=%h want=%h", params_a, RV);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++;
    if ({busy_a, done_a, err_a} !== 3'b000 || params_a !== RV) begin
      n_bad++;
      $display("FAIL mid_load idle_after_release got=%b%b%b params=%h", busy_a, done_a, err_a, params_a);
    end
    run_load(1'b0, 1'b0, "post_reset_load");
  endtask

  task automatic test_random();
    bit sel;
    logic [DW-1:0] w;
    for (int it = 0; it < 10; it++) begin
      sel = 1'($urandom_range(0, 1));
      for (int i = 0; i < NP; i++) begin
        w = ($urandom_range(0, 15) == 0) ? RV[i*DW +: DW] : DW'($urandom);
        if (sel) mem_b[i] = w; else mem_a[i] = w;
      end
      run_load(sel, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    nom = '{32'd448, 32'd232, 32'd103936, 32'd8, 32'd200, 32'd21,
            32'd10, 32'd11, 32'd11, 32'd0, 32'd1};
    mem_a = nom;
    mem_b = nom;
    test_reset();
    test_sentinel_fail();
    test_nominal();
    test_mask_latency();
    test_busy_reload();
    test_reset_mid_load();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
